// File: rtl/render_pkg.sv
// Shared types and default geometry for the line render sequencer.
package render_pkg;

    localparam int unsigned DISPLAY_WIDTH_DEF  = 600;
    localparam int unsigned DISPLAY_HEIGHT_DEF = 480;
    localparam int unsigned V_TOTAL_DEF        = 525;
    localparam int unsigned LINE_W_DEF         = $clog2(DISPLAY_WIDTH_DEF);

    typedef logic [LINE_W_DEF-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DRAW,
        HOLD
    } state_t;

endpackage

// File: rtl/line_render_sequencer.sv
// Sequences per-line sprite evaluation and drawing into a double-buffered line
// store, swapping buffers at the horizontal boundary and flagging missed lines.
module line_render_sequencer
    import render_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH     = DISPLAY_WIDTH_DEF,
    parameter int unsigned DISPLAY_HEIGHT    = DISPLAY_HEIGHT_DEF,
    parameter int unsigned V_TOTAL           = V_TOTAL_DEF,
    parameter int unsigned LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LINE_NUMBER_WIDTH-1:0] sx,
    input  logic [LINE_NUMBER_WIDTH-1:0] sy,
    input  logic                         frame_enable,
    output logic                         prep_start,
    input  logic                         prep_done,
    output logic                         draw_enable,
    input  logic                         draw_done,
    output logic [LINE_NUMBER_WIDTH-1:0] render_line,
    output logic                         buf_sel,
    output logic                         line_ready,
    output logic                         overrun,
    output logic [7:0]                   overrun_count
);

    localparam logic [LINE_NUMBER_WIDTH-1:0] SX_LAST = LINE_NUMBER_WIDTH'(DISPLAY_WIDTH - 1);
    localparam logic [LINE_NUMBER_WIDTH-1:0] SY_LAST = LINE_NUMBER_WIDTH'(V_TOTAL - 1);
    localparam logic [LINE_NUMBER_WIDTH-1:0] VIS_H   = LINE_NUMBER_WIDTH'(DISPLAY_HEIGHT);

    state_t                       state;
    state_t                       state_n;
    logic                         boundary;
    logic [LINE_NUMBER_WIDTH-1:0] next_line;
    logic                         job_start;
    logic                         enter_prep;
    logic                         swap;
    logic                         miss;

    always_comb begin
        boundary   = (sx == SX_LAST);
        next_line  = (sy == SY_LAST) ? '0 : sy + LINE_NUMBER_WIDTH'(1);
        job_start  = (next_line < VIS_H) && frame_enable;
        state_n    = state;
        enter_prep = 1'b0;
        swap       = 1'b0;
        miss       = 1'b0;
        // Every boundary resolves to PREP or IDLE; only the swap/overrun side
        // effect depends on where the current job had got to.
        if (boundary) begin
            enter_prep = job_start;
            state_n    = job_start ? PREP : IDLE;
            case (state)
                PREP:    miss = 1'b1;
                DRAW:    begin
                    swap = draw_done;
                    miss = !draw_done;
                end
                HOLD:    swap = 1'b1;
                default: ;
            endcase
        end else begin
            case (state)
                PREP:    if (prep_done) state_n = DRAW;
                DRAW:    if (draw_done) state_n = HOLD;
                default: ;
            endcase
        end
        draw_enable = (state == DRAW);
        line_ready  = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            prep_start    <= 1'b0;
            render_line   <= '0;
            buf_sel       <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state      <= state_n;
            prep_start <= enter_prep;
            if (enter_prep)
                render_line <= next_line;
            if (swap)
                buf_sel <= !buf_sel;
            if (miss) begin
                overrun <= 1'b1;
                if (overrun_count != '1)
                    overrun_count <= overrun_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_render_sequencer.sv
// Directed self-checking bench for line_render_sequencer.
module tb_line_render_sequencer;
    import render_pkg::*;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sx;
    logic [W-1:0] sy;
    logic         frame_enable;
    logic         prep_start;
    logic         prep_done;
    logic         draw_enable;
    logic         draw_done;
    logic [W-1:0] render_line;
    logic         buf_sel;
    logic         line_ready;
    logic         overrun;
    logic [7:0]   overrun_count;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    line_render_sequencer #(
        .DISPLAY_WIDTH(600),
        .DISPLAY_HEIGHT(480),
        .V_TOTAL(525),
        .LINE_NUMBER_WIDTH(W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sx(sx),
        .sy(sy),
        .frame_enable(frame_enable),
        .prep_start(prep_start),
        .prep_done(prep_done),
        .draw_enable(draw_enable),
        .draw_done(draw_done),
        .render_line(render_line),
        .buf_sel(buf_sel),
        .line_ready(line_ready),
        .overrun(overrun),
        .overrun_count(overrun_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (prep_start === 1'b1) pulses++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic boundary(input logic [W-1:0] line);
        sy = line;
        sx = 10'd599;
        tick();
        sx = '0;
    endtask

    task automatic pulse_prep_done();
        prep_done = 1'b1;
        tick();
        prep_done = 1'b0;
    endtask

    task automatic pulse_draw_done();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset with completions and a job-worthy boundary all asserted
        reset = 1'b1; frame_enable = 1'b1; sy = 10'd9; sx = 10'd599;
        prep_done = 1'b1; draw_done = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        chk("rst_prep_start", prep_start, 0);
        chk("rst_draw_enable", draw_enable, 0);
        chk("rst_line_ready", line_ready, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_render_line", render_line, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_count", overrun_count, 0);
        reset = 1'b0; prep_done = 1'b0; draw_done = 1'b0; sx = '0;

        // Normal line
        pulses = 0;
        boundary(10'd9);
        chk("norm_render_line", render_line, 10);
        chk("norm_prep_start_hi", prep_start, 1);
        chk("norm_state_prep", 32'(dut.state), 32'(PREP));
        tick();
        chk("norm_prep_start_lo", prep_start, 0);
        idle_cycles(38);
        pulse_prep_done();
        chk("norm_draw_enable_on", draw_enable, 1);
        idle_cycles(299);
        chk("norm_draw_enable_held", draw_enable, 1);
        pulse_draw_done();
        chk("norm_draw_enable_off", draw_enable, 0);
        chk("norm_line_ready", line_ready, 1);
        chk("norm_buf_before", buf_sel, 0);
        chk("norm_one_pulse", pulses, 1);
        boundary(10'd10);
        chk("norm_buf_after", buf_sel, 1);
        chk("norm_overrun", overrun, 0);
        chk("norm_line_ready_off", line_ready, 0);
        chk("norm_next_render_line", render_line, 11);

        // Overrun across three boundaries
        do_reset();
        boundary(10'd19);
        pulses = 0;
        pulse_prep_done();
        idle_cycles(20);
        boundary(10'd20);
        chk("ovr_first_count", overrun_count, 1);
        chk("ovr_draw_dropped", draw_enable, 0);
        idle_cycles(20);
        boundary(10'd21);
        idle_cycles(20);
        boundary(10'd22);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", overrun_count, 3);
        chk("ovr_buf_sel", buf_sel, 0);
        chk("ovr_pulses", pulses, 3);
        chk("ovr_render_line", render_line, 23);

        // Frame wrap and end of visible area
        do_reset();
        boundary(10'd524);
        chk("wrap_render_line", render_line, 0);
        pulse_prep_done();
        pulse_draw_done();
        chk("wrap_line_ready", line_ready, 1);
        boundary(10'd0);
        chk("wrap_next_render", render_line, 1);
        chk("wrap_buf_sel", buf_sel, 1);
        pulse_prep_done();
        pulse_draw_done();
        chk("last_hold", 32'(dut.state), 32'(HOLD));
        boundary(10'd479);
        chk("last_state_idle", 32'(dut.state), 32'(IDLE));
        chk("last_buf_swap", buf_sel, 0);
        chk("last_line_ready", line_ready, 0);
        chk("last_no_prep", prep_start, 0);
        chk("last_render_kept", render_line, 1);
        boundary(10'd480);
        chk("blank_idle", 32'(dut.state), 32'(IDLE));
        chk("blank_buf_sel", buf_sel, 0);
        chk("blank_overrun", overrun, 0);

        // draw_done coinciding with the boundary
        do_reset();
        boundary(10'd30);
        pulse_prep_done();
        idle_cycles(5);
        draw_done = 1'b1;
        boundary(10'd31);
        draw_done = 1'b0;
        chk("sim_buf_sel", buf_sel, 1);
        chk("sim_overrun_count", overrun_count, 0);
        chk("sim_overrun", overrun, 0);
        chk("sim_render_line", render_line, 32);
        chk("sim_prep_start", prep_start, 1);
        chk("sim_state_prep", 32'(dut.state), 32'(PREP));

        // frame_enable dropped mid-job: job completes, no new job
        pulse_prep_done();
        frame_enable = 1'b0;
        idle_cycles(3);
        pulse_draw_done();
        pulses = 0;
        boundary(10'd32);
        chk("fe_off_state_idle", 32'(dut.state), 32'(IDLE));
        chk("fe_off_buf_swap", buf_sel, 0);
        chk("fe_off_no_pulse", pulses, 0);
        frame_enable = 1'b1;

        // Reset during DRAW, with late completions
        boundary(10'd99);
        boundary(10'd100);
        pulse_prep_done();
        chk("mid_draw_enable", draw_enable, 1);
        chk("mid_overrun", overrun, 1);
        reset = 1'b1; prep_done = 1'b1; draw_done = 1'b1;
        tick();
        chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_draw_enable", draw_enable, 0);
        chk("mid_rst_render_line", render_line, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_overrun_count", overrun_count, 0);
        chk("mid_rst_prep_start", prep_start, 0);
        reset = 1'b0;
        tick();
        prep_done = 1'b0; draw_done = 1'b0;
        chk("late_done_state", 32'(dut.state), 32'(IDLE));
        chk("late_done_buf_sel", buf_sel, 0);
        chk("late_done_line_ready", line_ready, 0);
        chk("late_done_draw_enable", draw_enable, 0);

        // Saturation of the overrun counter
        do_reset();
        boundary(10'd200);
        for (int i = 0; i < 254; i++) boundary(10'd200);
        chk("sat_254", overrun_count, 254);
        for (int i = 0; i < 6; i++) boundary(10'd200);
        chk("sat_count", overrun_count, 255);
        chk("sat_overrun", overrun, 1);
        chk("sat_render_line", render_line, 201);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
